// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates the register-file write port between the execute result and load responses, and tracks pending loads.
// Optional macro REGFILE_WB_RR_ARB_EN selects round-robin conflict resolution instead of fixed load priority.
module regfile_wb_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned REG_FILE_SIZE = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0]    ex_data,
    input  logic                     ld_issue,
    input  logic [REG_ADDR_BITS-1:0] ld_issue_rd,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [REG_ADDR_BITS-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic [REG_ADDR_BITS-1:0] rs1_addr,
    input  logic [REG_ADDR_BITS-1:0] rs2_addr,
    output logic                     rs_stall,
    output logic                     rf_we,
    output logic [REG_ADDR_BITS-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic                     sb_err
);

    logic [REG_FILE_SIZE-1:0] sb;
    logic [REG_FILE_SIZE-1:0] sb_next;
    logic                     err_next;
    logic                     ex_ok;
    logic                     conflict;
    logic                     ld_acc;
    logic                     ex_acc;

    // Execute is only eligible when its destination has no outstanding load (WAW ordering).
    assign ex_ok    = ex_valid & ~sb[ex_rd];
    assign conflict = ld_valid & ex_ok;

`ifdef REGFILE_WB_RR_ARB_EN
    logic rr_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ld <= 1'b1;
        end else if (conflict) begin
            rr_ld <= ~rr_ld;
        end
    end

    assign ld_ready = ld_valid & (~conflict | rr_ld);
    assign ex_ready = ex_ok & (~ld_valid | ~rr_ld);
`else
    assign ld_ready = ld_valid;
    assign ex_ready = ex_ok & ~ld_valid;
`endif

    assign ld_acc = ld_valid & ld_ready;
    assign ex_acc = ex_valid & ex_ready;

    assign rs_stall = ((rs1_addr != '0) & sb[rs1_addr]) | ((rs2_addr != '0) & sb[rs2_addr]);

    // Response clears first so a same-cycle issue to the same register leaves it pending.
    always_comb begin
        sb_next  = sb;
        err_next = sb_err;
        if (ld_acc && (ld_rd != '0)) begin
            sb_next[ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != '0)) begin
            if (sb_next[ld_issue_rd]) begin
                err_next = 1'b1;
            end
            sb_next[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb     <= '0;
            sb_err <= 1'b0;
        end else begin
            sb     <= sb_next;
            sb_err <= err_next;
        end
    end

    // Registered write port; writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (ld_acc) begin
            rf_we <= (ld_rd != '0);
            if (ld_rd != '0) begin
                rf_waddr <= ld_rd;
                rf_wdata <= ld_data;
            end
        end else if (ex_acc) begin
            rf_we <= (ex_rd != '0);
            if (ex_rd != '0) begin
                rf_waddr <= ex_rd;
                rf_wdata <= ex_data;
            end
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule
